// File: rtl/uart_if.sv
// Byte-side and serial-line signals of the UART, bundled so the core and
// its user share a single port.
interface uart_if;
    logic [7:0] din;
    logic       wr_en;
    logic       tx;
    logic       tx_busy;
    logic       rx;
    logic       rdy;
    logic       rdy_clr;
    logic [7:0] dout;

    modport master (
        output din, wr_en, rx, rdy_clr,
        input  tx, tx_busy, rdy, dout
    );

    modport slave (
        input  din, wr_en, rx, rdy_clr,
        output tx, tx_busy, rdy, dout
    );
endinterface

// File: rtl/uart.sv
// 8N1 UART: independent transmitter and receiver. Every bit lasts CLKS_PER_BIT
// clocks, and each bit timer is a down-counter that acts on terminal count.
//
// state    | meaning
// TX_IDLE  | line high, accepts a write
// TX_START | start bit (0)
// TX_DATA  | 8 data bits, LSB first
// TX_STOP  | stop bit (1)
// RX_IDLE  | waiting for a low on the line (after a framing error, the line must go high first)
// RX_START | half-bit delay, then confirm the start bit
// RX_DATA  | sample 8 bits at mid-bit
// RX_STOP  | sample the stop bit, then deliver the byte or drop it
module uart #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input logic   clk_50m,
    input logic   rst,
    uart_if.slave bus
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    tx_state_t        r_tx_state, w_tx_state_nxt;
    logic [CNT_W-1:0] r_tx_cnt, w_tx_cnt_nxt;
    logic [2:0]       r_tx_idx, w_tx_idx_nxt;
    logic [7:0]       r_tx_shift, w_tx_shift_nxt;
    logic             r_tx, w_tx_nxt;
    logic             r_tx_busy, w_tx_busy_nxt;
    logic             w_tx_tc;

    rx_state_t        r_rx_state, w_rx_state_nxt;
    logic [CNT_W-1:0] r_rx_cnt, w_rx_cnt_nxt;
    logic [2:0]       r_rx_idx, w_rx_idx_nxt;
    logic [7:0]       r_rx_shift, w_rx_shift_nxt;
    logic             r_rx_armed, w_rx_armed_nxt;
    logic [7:0]       r_dout, w_dout_nxt;
    logic             r_rdy, w_rdy_nxt;
    logic [1:0]       r_sync;
    logic             w_rx_s;
    logic             w_rx_tc;
    logic             w_rx_done;

    assign w_tx_tc = (r_tx_cnt == '0);
    assign w_rx_tc = (r_rx_cnt == '0);
    assign w_rx_s  = r_sync[1];

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt;
        w_tx_idx_nxt   = r_tx_idx;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_nxt       = r_tx;
        w_tx_busy_nxt  = r_tx_busy;
        unique case (r_tx_state)
            TX_IDLE: begin
                w_tx_nxt      = 1'b1;
                w_tx_busy_nxt = 1'b0;
                if (bus.wr_en) begin
                    w_tx_state_nxt = TX_START;
                    w_tx_cnt_nxt   = BIT_LAST;
                    w_tx_idx_nxt   = 3'd0;
                    w_tx_shift_nxt = bus.din;
                    w_tx_nxt       = 1'b0;
                    w_tx_busy_nxt  = 1'b1;
                end
            end
            TX_START: begin
                if (w_tx_tc) begin
                    w_tx_state_nxt = TX_DATA;
                    w_tx_cnt_nxt   = BIT_LAST;
                    w_tx_nxt       = r_tx_shift[0];
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt - CNT_ONE;
                end
            end
            TX_DATA: begin
                if (w_tx_tc) begin
                    w_tx_cnt_nxt = BIT_LAST;
                    if (r_tx_idx == 3'd7) begin
                        w_tx_state_nxt = TX_STOP;
                        w_tx_nxt       = 1'b1;
                    end else begin
                        w_tx_idx_nxt   = r_tx_idx + 3'd1;
                        w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
                        w_tx_nxt       = r_tx_shift[1];
                    end
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt - CNT_ONE;
                end
            end
            TX_STOP: begin
                if (w_tx_tc) begin
                    w_tx_state_nxt = TX_IDLE;
                    w_tx_busy_nxt  = 1'b0;
                    w_tx_nxt       = 1'b1;
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt - CNT_ONE;
                end
            end
            default: w_tx_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_idx   <= 3'd0;
            r_tx_shift <= 8'h00;
            r_tx       <= 1'b1;
            r_tx_busy  <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_idx   <= w_tx_idx_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tx       <= w_tx_nxt;
            r_tx_busy  <= w_tx_busy_nxt;
        end
    end

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt;
        w_rx_idx_nxt   = r_rx_idx;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_armed_nxt = r_rx_armed;
        w_dout_nxt     = r_dout;
        w_rx_done      = 1'b0;
        unique case (r_rx_state)
            RX_IDLE: begin
                if (w_rx_s) begin
                    w_rx_armed_nxt = 1'b1;
                end else if (r_rx_armed) begin
                    w_rx_state_nxt = RX_START;
                    w_rx_cnt_nxt   = HALF_LAST;
                end
            end
            RX_START: begin
                if (w_rx_tc) begin
                    if (!w_rx_s) begin
                        w_rx_state_nxt = RX_DATA;
                        w_rx_cnt_nxt   = BIT_LAST;
                        w_rx_idx_nxt   = 3'd0;
                    end else begin
                        w_rx_state_nxt = RX_IDLE;
                    end
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt - CNT_ONE;
                end
            end
            RX_DATA: begin
                if (w_rx_tc) begin
                    w_rx_cnt_nxt   = BIT_LAST;
                    w_rx_shift_nxt = {w_rx_s, r_rx_shift[7:1]};
                    if (r_rx_idx == 3'd7) begin
                        w_rx_state_nxt = RX_STOP;
                    end else begin
                        w_rx_idx_nxt = r_rx_idx + 3'd1;
                    end
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt - CNT_ONE;
                end
            end
            RX_STOP: begin
                if (w_rx_tc) begin
                    w_rx_state_nxt = RX_IDLE;
                    if (w_rx_s) begin
                        w_rx_done  = 1'b1;
                        w_dout_nxt = r_rx_shift;
                    end else begin
                        w_rx_armed_nxt = 1'b0;
                    end
                end else begin
                    w_rx_cnt_nxt = r_rx_cnt - CNT_ONE;
                end
            end
            default: w_rx_state_nxt = RX_IDLE;
        endcase
    end

    // A completing byte takes priority over a simultaneous clear.
    always_comb begin
        w_rdy_nxt = r_rdy;
        if (bus.rdy_clr) w_rdy_nxt = 1'b0;
        if (w_rx_done)   w_rdy_nxt = 1'b1;
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            r_sync     <= 2'b11;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_idx   <= 3'd0;
            r_rx_shift <= 8'h00;
            r_rx_armed <= 1'b1;
            r_dout     <= 8'h00;
            r_rdy      <= 1'b0;
        end else begin
            r_sync     <= {r_sync[0], bus.rx};
            r_rx_state <= w_rx_state_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_idx   <= w_rx_idx_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_rx_armed <= w_rx_armed_nxt;
            r_dout     <= w_dout_nxt;
            r_rdy      <= w_rdy_nxt;
        end
    end

    assign bus.tx      = r_tx;
    assign bus.tx_busy = r_tx_busy;
    assign bus.rdy     = r_rdy;
    assign bus.dout    = r_dout;
endmodule

// File: tb/tb_uart.sv
// Directed and randomized bench for uart; expected line waveforms and
// received bytes come from 8N1 framing rules kept in the bench.
module tb_uart;
    localparam int CLK_FREQ = 1000000;
    localparam int BAUD     = 57600;
    localparam int CPB      = CLK_FREQ / BAUD;   // 17 clocks per bit

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = 8'h00;
    logic       wr_en = 1'b0;
    logic       rdy_clr = 1'b0;
    logic       rx_drv = 1'b1;
    logic       loop_en = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_dout;
    logic       exp_rdy;

    uart_if u_bus ();
    assign u_bus.din     = din;
    assign u_bus.wr_en   = wr_en;
    assign u_bus.rdy_clr = rdy_clr;
    assign u_bus.rx      = loop_en ? u_bus.tx : rx_drv;

    uart #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk_50m (clk),
        .rst     (rst),
        .bus     (u_bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Called at a negedge where the transmitter is idle; returns at the
    // negedge of the first idle cycle after the frame.
    task automatic send_tx(input logic [7:0] b, input bit inject);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        din   = b;
        wr_en = 1'b1;
        for (int i = 0; i < 10 * CPB; i++) begin
            @(negedge clk);
            wr_en = 1'b0;
            if (inject && i == 4 * CPB) begin
                din   = 8'hFF;
                wr_en = 1'b1;
            end
            chk("tx_line", u_bus.tx, fr[i / CPB]);
            chk("tx_busy", u_bus.tx_busy, 1);
        end
        @(negedge clk);
        wr_en = 1'b0;
        chk("tx_idle_line", u_bus.tx, 1);
        chk("tx_busy_end", u_bus.tx_busy, 0);
    endtask

    // Drives one frame on rx starting at the current negedge; optionally
    // pulses rdy_clr at negedge index clr_at; reports the negedge index at
    // which rdy first reads high (when it started low).
    task automatic rx_frame(input logic [7:0] b, input logic stop, input int clr_at, output int lat);
        logic [9:0] fr;
        logic       rdy0;
        fr   = {stop, b, 1'b0};
        rdy0 = u_bus.rdy;
        lat  = -1;
        for (int k = 0; k < 10 * CPB; k++) begin
            rx_drv  = fr[k / CPB];
            rdy_clr = (k == clr_at);
            @(negedge clk);
            if (lat < 0 && rdy0 !== 1'b1 && u_bus.rdy === 1'b1) lat = k + 1;
        end
        rx_drv  = 1'b1;
        rdy_clr = 1'b0;
        if (stop) begin
            exp_dout = b;
            exp_rdy  = 1'b1;
        end
    endtask

    task automatic clear_rdy();
        rdy_clr = 1'b1;
        @(negedge clk);
        rdy_clr = 1'b0;
        exp_rdy = 1'b0;
    endtask

    initial begin
        int         lat;
        int         lat_ref;
        int         dummy;
        logic [7:0] a;
        logic [7:0] b;
        logic       stop;

        exp_dout = 8'h00;
        exp_rdy  = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_tx", u_bus.tx, 1);
        chk("rst_busy", u_bus.tx_busy, 0);
        chk("rst_rdy", u_bus.rdy, 0);
        chk("rst_dout", u_bus.dout, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        // Transmit: fixed pattern, back-to-back random byte, ignored mid-frame write.
        send_tx(8'hA5, 1'b0);
        a = 8'($urandom);
        send_tx(a, 1'b0);
        send_tx(8'h55, 1'b1);
        repeat (2) @(negedge clk);
        chk("tx_after_ignored_wr", u_bus.tx_busy, 0);

        // Loopback of 0x41, then clear.
        loop_en = 1'b1;
        send_tx(8'h41, 1'b0);
        exp_dout = 8'h41;
        exp_rdy  = 1'b1;
        chk("loop_rdy", u_bus.rdy, exp_rdy);
        chk("loop_dout", u_bus.dout, exp_dout);
        loop_en = 1'b0;
        clear_rdy();
        chk("loop_rdy_clr", u_bus.rdy, 0);
        chk("loop_dout_kept", u_bus.dout, 8'h41);

        // Short low glitch must not start a reception.
        rx_drv = 1'b0;
        repeat (CPB / 2 - 3) @(negedge clk);
        rx_drv = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        chk("glitch_rdy", u_bus.rdy, 0);
        chk("glitch_dout", u_bus.dout, exp_dout);

        // Framing error is dropped, and the next good frame is still received.
        rx_frame(8'h3C, 1'b0, -1, dummy);
        repeat (4) @(negedge clk);
        chk("frame_err_rdy", u_bus.rdy, 0);
        chk("frame_err_dout", u_bus.dout, exp_dout);
        b = 8'($urandom);
        rx_frame(b, 1'b1, -1, dummy);
        repeat (4) @(negedge clk);
        chk("after_err_rdy", u_bus.rdy, exp_rdy);
        chk("after_err_dout", u_bus.dout, exp_dout);
        clear_rdy();

        // Overwrite while rdy is set; clear coinciding with completion loses.
        rx_frame(8'h31, 1'b1, -1, lat_ref);
        repeat (4) @(negedge clk);
        chk("rx31_rdy", u_bus.rdy, 1);
        chk("rx31_dout", u_bus.dout, 8'h31);
        chk("rx_latency_window", (lat_ref >= 9 * CPB && lat_ref <= 10 * CPB), 1);
        rx_frame(8'h32, 1'b1, lat_ref - 1, dummy);
        repeat (4) @(negedge clk);
        chk("rx32_rdy", u_bus.rdy, 1);
        chk("rx32_dout", u_bus.dout, 8'h32);

        // Simultaneous random transmit and receive.
        for (int n = 0; n < 5; n++) begin
            a    = 8'($urandom);
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            clear_rdy();
            chk("dup_rdy_cleared", u_bus.rdy, 0);
            fork
                send_tx(a, 1'b0);
                rx_frame(b, stop, -1, dummy);
            join
            repeat (4) @(negedge clk);
            chk("dup_rdy", u_bus.rdy, exp_rdy);
            chk("dup_dout", u_bus.dout, exp_dout);
        end

        // Reset in the middle of both a transmit and a receive frame.
        rx_frame(8'h6B, 1'b1, -1, dummy);
        repeat (4) @(negedge clk);
        chk("pre_rst_rdy", u_bus.rdy, 1);
        a     = 8'($urandom);
        din   = a;
        wr_en = 1'b1;
        for (int k = 0; k < 5 * CPB; k++) begin
            rx_drv = (k < CPB) ? 1'b0 : ((k / CPB) % 2 == 1);
            @(negedge clk);
            wr_en = 1'b0;
        end
        chk("mid_frame_busy", u_bus.tx_busy, 1);
        rst    = 1'b1;
        rx_drv = 1'b0;
        wr_en  = 1'b1;
        @(negedge clk);
        chk("mid_rst_tx", u_bus.tx, 1);
        chk("mid_rst_busy", u_bus.tx_busy, 0);
        chk("mid_rst_rdy", u_bus.rdy, 0);
        chk("mid_rst_dout", u_bus.dout, 8'h00);
        exp_dout = 8'h00;
        exp_rdy  = 1'b0;
        @(negedge clk);
        chk("in_rst_busy", u_bus.tx_busy, 0);
        rst    = 1'b0;
        wr_en  = 1'b0;
        rx_drv = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        chk("post_rst_busy", u_bus.tx_busy, 0);
        chk("post_rst_rdy", u_bus.rdy, exp_rdy);
        chk("post_rst_dout", u_bus.dout, exp_dout);
        a = 8'($urandom);
        send_tx(a, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
